muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Sequencing controller for the shared multi-cycle multiplier and divider, and owner of the HI/LO architectural registers.
- Accepts one HI/LO-class request from the execute stage (MULT/DIV/MTHI/MTLO) and drives the unit's level-held begin signal.
- Stalls the execute stage, commits results to HI/LO, and aborts cleanly on pipeline flush or unit timeout.

Parameters:
- TIMEOUT, 64, max cycles in MUL/DIV before forced abort (must be ≥ unit latency + 2).
- CNT_W, 7, width of the busy-cycle counter (2^CNT_W > TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a HI/LO-class instruction
- req_op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
- req_sign  in  1  signed operation (MULT/DIV)
- req_op1  in  32  rs value
- req_op2  in  32  rt value
- flush  in  1  pipeline flush (exception/ERET); cancels the current request
- req_ready  out  1  request accepted this cycle
- exe_stall  out  1  hold the execute stage
- done  out  1  one-cycle completion pulse
- mult_begin  out  1  level start/hold to the multiplier
- div_begin  out  1  level start/hold to the divider
- unit_sign  out  1  latched sign to the unit
- unit_op1  out  32  latched operand 1
- unit_op2  out  32  latched operand 2
- mult_end  in  1  multiplier result valid
- product  in  64  multiplier result
- div_end  in  1  divider result valid
- quotient  in  32  divider quotient
- remainder  in  32  divider remainder
- hi_out  out  32  HI register
- lo_out  out  32  LO register
- timeout_err  out  1  sticky; set on a timeout abort

Behaviour:
- Reset: asynchronous, active-low.
  - State = IDLE.
  - hi_out, lo_out, unit_op1, unit_op2 = 0.
  - unit_sign, counter, timeout_err = 0.
  - All strobes and begins = 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - req_ready = req_valid & ~flush (combinational).
  - On acceptance, latch op1, op2 and sign.
- IDLE transitions on acceptance:
  - MTHI: hi_out ← op1 at the edge; go to DONE.
  - MTLO: lo_out ← op1 at the edge; go to DONE.
  - MULT: go to MUL.
  - DIV with op2 ≠ 0: go to DIV.
  - DIV with op2 = 0: go to DONE with no HI/LO write and divider never started.
- MUL: mult_begin = 1 for the whole state; counter increments each cycle.
  - On mult_end & ~flush: hi ← product[63:32], lo ← product[31:0]; go to DONE.
- DIV: div_begin = 1 for the whole state; counter increments each cycle.
  - On div_end & ~flush: hi ← remainder, lo ← quotient; go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
  - A new request can be accepted in the following cycle, giving a minimum 2-cycle issue interval.
- exe_stall = (state == MUL) | (state == DIV) | (state == IDLE & req_valid & ~req_op[1] & ~flush).
  - The stall covers the accepting cycle of MULT/DIV.
  - The stall drops in the DONE cycle.
- Flush:
  - In MUL or DIV: next state is IDLE; begin drops the next cycle (the unit treats a dropped begin as abort); no HI/LO write; no done pulse.
  - Flush wins over a simultaneous mult_end or div_end.
  - Flush in DONE has no effect, because the write is already committed.
- Timeout: when the counter reaches TIMEOUT in MUL or DIV:
  - Abort to IDLE with no write and no done pulse.
  - Set timeout_err; it clears only on reset.
- Counter clears on entering MUL or DIV.
- Requests while not in IDLE are ignored (req_ready = 0); the requester holds req_valid.
- mult_end is ignored in DIV; div_end is ignored in MUL.
- Operands and sign stay stable for the whole MUL/DIV residency, independent of changes on req_*.
- hi_out and lo_out update only at the commit edge; they are visible the cycle after commit for MFHI/MFLO forwarding.

Test Plan:
- MULT signed, op1 = 0xFFFFFFFE (−2), op2 = 3; unit returns mult_end after 32 cycles with product = 0xFFFFFFFFFFFFFFFA.
  - → hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.
  - → done pulses once; exe_stall high from the accept cycle through the mult_end cycle; mult_begin high throughout MUL.
- DIV unsigned, 100 / 7, divider returns quotient = 14, remainder = 2 → lo = 14, hi = 2; div_begin never high during the preceding MTLO.
- DIV with op2 = 0 → div_begin stays 0; done one cycle after accept; HI/LO unchanged from prior values.
- MULT in progress with flush asserted in the same cycle as mult_end → no HI/LO write, no done pulse, state IDLE, mult_begin low the next cycle.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back with req_valid held.
  - → second accepted two cycles after the first.
  - → final hi = 0x12345678, lo = 0x9ABCDEF0.
- Multiplier stub never asserts mult_end, TIMEOUT = 64 → abort after 64 cycles in MUL; timeout_err = 1 until resetn goes low; asynchronous reset mid-MUL clears all state immediately.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Request handshake between the execute stage and the HI/LO controller.
// master = execute stage (requester), slave = muldiv_ctrl.
interface muldiv_ctrl_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic        req_sign;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic        req_ready;

  modport master (
    output req_valid, req_op, req_sign, req_op1, req_op2,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_sign, req_op1, req_op2,
    output req_ready
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multi-cycle multiplier/divider; owns the HI/LO
// registers, stalls execute while a unit runs, aborts on flush or timeout.
module muldiv_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic          clk,
  input  logic          resetn,
  muldiv_ctrl_if.slave  req,
  input  logic          flush,
  output logic          exe_stall,
  output logic          done,
  output logic          mult_begin,
  output logic          div_begin,
  output logic          unit_sign,
  output logic [31:0]   unit_op1,
  output logic [31:0]   unit_op2,
  input  logic          mult_end,
  input  logic [63:0]   product,
  input  logic          div_end,
  input  logic [31:0]   quotient,
  input  logic [31:0]   remainder,
  output logic [31:0]   hi_out,
  output logic [31:0]   lo_out,
  output logic          timeout_err
);

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  // The last busy cycle is the one in which the counter is about to hit TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             commit_mul;
  logic             commit_div;
  logic             timed_out;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Flush beats a simultaneous unit completion; completion beats timeout.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    commit_mul = 1'b0;
    commit_div = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (req.req_valid && !flush) begin
          accept = 1'b1;
          case (req.req_op)
            OP_MULT: state_next = MUL;
            OP_DIV:  state_next = (req.req_op2 != '0) ? DIV : DONE;
            default: state_next = DONE;
          endcase
        end
      end
      MUL: begin
        if (flush) begin
          state_next = IDLE;
        end else if (mult_end) begin
          commit_mul = 1'b1;
          state_next = DONE;
        end else if (cnt == CNT_LAST) begin
          timed_out  = 1'b1;
          state_next = IDLE;
        end
      end
      DIV: begin
        if (flush) begin
          state_next = IDLE;
        end else if (div_end) begin
          commit_div = 1'b1;
          state_next = DONE;
        end else if (cnt == CNT_LAST) begin
          timed_out  = 1'b1;
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req.req_ready = accept;
  assign done          = (state == DONE);
  assign mult_begin    = (state == MUL);
  assign div_begin     = (state == DIV);
  assign exe_stall     = (state == MUL) || (state == DIV) ||
                         ((state == IDLE) && req.req_valid && !req.req_op[1] && !flush);

  // Operands are captured once at acceptance so the unit sees stable inputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      unit_op1  <= '0;
      unit_op2  <= '0;
      unit_sign <= 1'b0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        unit_op1  <= req.req_op1;
        unit_op2  <= req.req_op2;
        unit_sign <= req.req_sign;
      end
      if (accept) begin
        cnt <= '0;
      end else if ((state == MUL) || (state == DIV)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_out      <= '0;
      lo_out      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept && (req.req_op == OP_MTHI)) begin
        hi_out <= req.req_op1;
      end
      if (accept && (req.req_op == OP_MTLO)) begin
        lo_out <= req.req_op1;
      end
      if (commit_mul) begin
        hi_out <= product[63:32];
        lo_out <= product[31:0];
      end
      if (commit_div) begin
        hi_out <= remainder;
        lo_out <= quotient;
      end
      if (timed_out) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed test for muldiv_ctrl: a done-driven scoreboard checks HI/LO commits
// while the stimulus thread checks timing, stalls, flush, timeout and reset.
module tb_muldiv_ctrl;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        exe_stall, done, mult_begin, div_begin, unit_sign;
  logic [31:0] unit_op1, unit_op2;
  logic        mult_end, div_end;
  logic [63:0] product;
  logic [31:0] quotient, remainder;
  logic [31:0] hi_out, lo_out;
  logic        timeout_err;

  muldiv_ctrl_if req_bus ();

  muldiv_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req_bus),
    .flush       (flush),
    .exe_stall   (exe_stall),
    .done        (done),
    .mult_begin  (mult_begin),
    .div_begin   (div_begin),
    .unit_sign   (unit_sign),
    .unit_op1    (unit_op1),
    .unit_op2    (unit_op2),
    .mult_end    (mult_end),
    .product     (product),
    .div_end     (div_end),
    .quotient    (quotient),
    .remainder   (remainder),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Unit stub: result appears after a programmable number of begin-high cycles.
  int       mult_lat = 32;
  int       div_lat  = 8;
  bit       mult_en  = 1'b1;
  logic [7:0] mcnt, dcnt;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcnt <= '0;
      dcnt <= '0;
    end else begin
      mcnt <= mult_begin ? mcnt + 8'd1 : 8'd0;
      dcnt <= div_begin  ? dcnt + 8'd1 : 8'd0;
    end
  end

  assign mult_end  = mult_begin && mult_en && (int'(mcnt) == mult_lat - 1);
  assign div_end   = div_begin && (int'(dcnt) == div_lat - 1);
  assign product   = unit_sign ? ({{32{unit_op1[31]}}, unit_op1} * {{32{unit_op2[31]}}, unit_op2})
                               : ({32'd0, unit_op1} * {32'd0, unit_op2});
  assign quotient  = (unit_op2 == 32'd0) ? 32'd0 :
                     unit_sign ? 32'($signed(unit_op1) / $signed(unit_op2)) : unit_op1 / unit_op2;
  assign remainder = (unit_op2 == 32'd0) ? 32'd0 :
                     unit_sign ? 32'($signed(unit_op1) % $signed(unit_op2)) : unit_op1 % unit_op2;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];

  task automatic expect_result(input string name, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = name;
    e.hi   = hi;
    e.lo   = lo;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL spurious_done: done=1 at cycle %0d with nothing pending, required done=0", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output({e.name, "_hi"}, 64'(hi_out), 64'(e.hi));
        check_output({e.name, "_lo"}, 64'(lo_out), 64'(e.lo));
      end
    end
  end

  // Presents a request and holds it until accepted; returns at the negedge after the accept edge.
  task automatic apply_stimulus(input logic [1:0] op, input logic sign, input logic [31:0] op1,
                                input logic [31:0] op2, output int acc_cyc,
                                output logic acc_stall, output logic acc_dbeg);
    bit ok = 1'b0;
    acc_cyc   = -1;
    acc_stall = 1'b0;
    acc_dbeg  = 1'b0;
    req_bus.req_valid = 1'b1;
    req_bus.req_op    = op;
    req_bus.req_sign  = sign;
    req_bus.req_op1   = op1;
    req_bus.req_op2   = op2;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (req_bus.req_ready) begin
        ok        = 1'b1;
        acc_cyc   = cyc;
        acc_stall = exe_stall;
        acc_dbeg  = div_begin;
        break;
      end
      @(negedge clk);
    end
    check_output("request_accepted", 64'(ok), 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int   c1, c2, mb, st;
  logic s_acc, d_acc;
  bit   seen;

  initial begin
    req_bus.req_valid = 1'b0;
    req_bus.req_op    = 2'b00;
    req_bus.req_sign  = 1'b0;
    req_bus.req_op1   = '0;
    req_bus.req_op2   = '0;

    // Reset state
    @(negedge clk);
    #1;
    check_output("rst_hi", 64'(hi_out), 64'd0);
    check_output("rst_lo", 64'(lo_out), 64'd0);
    check_output("rst_op1", 64'(unit_op1), 64'd0);
    check_output("rst_op2", 64'(unit_op2), 64'd0);
    check_output("rst_strobes", 64'({done, mult_begin, div_begin, unit_sign, timeout_err, exe_stall}), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Signed MULT -2 * 3 with a 32-cycle multiplier
    $display("[TB] MULT signed -2 * 3");
    expect_result("mult_signed", 32'hFFFFFFFF, 32'hFFFFFFFA);
    apply_stimulus(OP_MULT, 1'b1, 32'hFFFFFFFE, 32'd3, c1, s_acc, d_acc);
    check_output("mult_accept_stall", 64'(s_acc), 64'd1);
    req_bus.req_valid = 1'b0;
    req_bus.req_op1   = 32'hDEADBEEF;
    req_bus.req_sign  = 1'b0;
    #1;
    check_output("mult_op1_latched", 64'(unit_op1), 64'hFFFFFFFE);
    check_output("mult_sign_latched", 64'(unit_sign), 64'd1);
    mb = 0; st = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (mult_begin) mb++;
      if (exe_stall) st++;
      @(negedge clk);
      #1;
    end
    check_output("mult_done_seen", 64'(seen), 64'd1);
    check_output("mult_begin_cycles", 64'(mb), 64'd32);
    check_output("mult_stall_cycles", 64'(st), 64'd32);
    check_output("mult_done_stall", 64'(exe_stall), 64'd0);
    @(negedge clk);
    #1;
    check_output("mult_done_one_pulse", 64'(done), 64'd0);

    // MTLO, then unsigned DIV 100 / 7
    $display("[TB] MTLO then DIV 100 / 7");
    @(negedge clk);
    expect_result("mtlo", 32'hFFFFFFFF, 32'h00000055);
    apply_stimulus(OP_MTLO, 1'b0, 32'h00000055, 32'd0, c1, s_acc, d_acc);
    check_output("mtlo_accept_stall", 64'(s_acc), 64'd0);
    check_output("mtlo_accept_div_begin", 64'(d_acc), 64'd0);
    #1;
    check_output("mtlo_done_div_begin", 64'(div_begin), 64'd0);
    req_bus.req_valid = 1'b0;
    @(negedge clk);
    expect_result("div_100_7", 32'd2, 32'd14);
    apply_stimulus(OP_DIV, 1'b0, 32'd100, 32'd7, c1, s_acc, d_acc);
    req_bus.req_valid = 1'b0;
    #1;
    mb = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (div_begin) mb++;
      @(negedge clk);
      #1;
    end
    check_output("div_done_seen", 64'(seen), 64'd1);
    check_output("div_begin_cycles", 64'(mb), 64'd8);

    // DIV by zero: done next cycle, no HI/LO write, divider untouched
    $display("[TB] DIV by zero");
    @(negedge clk);
    expect_result("div_by_zero", 32'd2, 32'd14);
    apply_stimulus(OP_DIV, 1'b0, 32'd55, 32'd0, c1, s_acc, d_acc);
    req_bus.req_valid = 1'b0;
    check_output("div0_accept_stall", 64'(s_acc), 64'd1);
    #1;
    check_output("div0_done_next", 64'(done), 64'd1);
    check_output("div0_div_begin", 64'(div_begin), 64'd0);

    // Flush arriving together with mult_end
    $display("[TB] MULT flushed on mult_end");
    mult_lat = 5;
    @(negedge clk);
    apply_stimulus(OP_MULT, 1'b0, 32'd7, 32'd9, c1, s_acc, d_acc);
    req_bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (mult_end) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_output("flush_mult_end_seen", 64'(seen), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_output("flush_mult_begin_low", 64'(mult_begin), 64'd0);
    check_output("flush_no_done", 64'(done), 64'd0);
    check_output("flush_no_stall", 64'(exe_stall), 64'd0);
    check_output("flush_hi_kept", 64'(hi_out), 64'd2);
    check_output("flush_lo_kept", 64'(lo_out), 64'd14);

    // MTHI then MTLO back to back with req_valid held
    $display("[TB] MTHI / MTLO back to back");
    @(negedge clk);
    expect_result("mthi", 32'h12345678, 32'd14);
    expect_result("mtlo_b2b", 32'h12345678, 32'h9ABCDEF0);
    apply_stimulus(OP_MTHI, 1'b0, 32'h12345678, 32'd0, c1, s_acc, d_acc);
    apply_stimulus(OP_MTLO, 1'b0, 32'h9ABCDEF0, 32'd0, c2, s_acc, d_acc);
    req_bus.req_valid = 1'b0;
    check_output("b2b_issue_interval", 64'(c2 - c1), 64'd2);
    @(negedge clk);
    #1;
    check_output("b2b_hi_final", 64'(hi_out), 64'h12345678);
    check_output("b2b_lo_final", 64'(lo_out), 64'h9ABCDEF0);

    // Multiplier never answers: timeout abort after 64 MUL cycles
    $display("[TB] MULT timeout");
    check_output("timeout_err_before", 64'(timeout_err), 64'd0);
    mult_en = 1'b0;
    @(negedge clk);
    apply_stimulus(OP_MULT, 1'b0, 32'd1, 32'd1, c1, s_acc, d_acc);
    req_bus.req_valid = 1'b0;
    #1;
    mb = 0;
    for (int i = 0; i < 200; i++) begin
      if (!mult_begin) break;
      mb++;
      @(negedge clk);
      #1;
    end
    check_output("timeout_mul_cycles", 64'(mb), 64'd64);
    check_output("timeout_err_set", 64'(timeout_err), 64'd1);
    check_output("timeout_no_done", 64'(done), 64'd0);
    check_output("timeout_hi_kept", 64'(hi_out), 64'h12345678);
    check_output("timeout_lo_kept", 64'(lo_out), 64'h9ABCDEF0);
    repeat (3) @(negedge clk);
    #1;
    check_output("timeout_err_sticky", 64'(timeout_err), 64'd1);

    // Asynchronous reset in the middle of a MUL
    $display("[TB] async reset mid-MUL");
    @(negedge clk);
    apply_stimulus(OP_MULT, 1'b1, 32'hFFFFFFFF, 32'd5, c1, s_acc, d_acc);
    req_bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_output("areset_mult_begin", 64'(mult_begin), 64'd0);
    check_output("areset_timeout_err", 64'(timeout_err), 64'd0);
    check_output("areset_hi", 64'(hi_out), 64'd0);
    check_output("areset_lo", 64'(lo_out), 64'd0);
    check_output("areset_op1", 64'(unit_op1), 64'd0);
    check_output("areset_sign", 64'(unit_sign), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    check_output("post_reset_idle", 64'({done, mult_begin, div_begin, exe_stall}), 64'd0);

    repeat (2) @(negedge clk);
    check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
